// File: rtl/alu_pipe.sv
// Single-stage brainf*ck-style ALU: registered instruction/value/pointer, cell write-back,
// pointer update, branches, multi-core SYNC barrier and a handshaked PRINT port.
module alu_pipe #(
   parameter int NCORES   = 4,
   parameter int DW       = 16,
   parameter int PW       = 16,
   parameter int PTR_INIT = 128
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [15:0]                     ins_in,
   input  logic [DW-1:0]                   val_in,
   input  logic                            fork_valid,
   input  logic [PW-1:0]                   fork_ptr,
   input  logic [NCORES*16-1:0]            all_ins,
   input  logic                            core_stall,
   input  logic                            print_ready,
   output logic [DW-1:0]                   val_out,
   output logic                            wb_en,
   output logic [PW-1:0]                   ptr_select,
   output logic [PW-1:0]                   ptr_wb,
   output logic [15:0]                     branch_val,
   output logic                            branch_en,
   output logic [DW-1:0]                   print_data,
   output logic                            print_valid,
   output logic                            stall,
   output logic [15:0]                     current_ins,
   output logic [$clog2(NCORES+1)-1:0]     num_syncs
);

   localparam int SW = $clog2(NCORES+1);

   localparam logic [3:0] OP_PLUS  = 4'h1;
   localparam logic [3:0] OP_MINUS = 4'h2;
   localparam logic [3:0] OP_INC   = 4'h3;
   localparam logic [3:0] OP_DEC   = 4'h4;
   localparam logic [3:0] OP_BRZ   = 4'h5;
   localparam logic [3:0] OP_BR    = 4'h6;
   localparam logic [3:0] OP_SYNC  = 4'h8;
   localparam logic [3:0] OP_PRINT = 4'h9;
   localparam logic [3:0] OP_ADDK  = 4'hA;
   localparam logic [3:0] OP_MOVK  = 4'hB;

   typedef enum logic {IDLE, HOLD} print_state_e;

   logic [15:0]   ins_q, ins_d;
   logic [DW-1:0] val_q, val_d;
   logic [PW-1:0] ptr_q, ptr_d;
   print_state_e  state_q, state_d;
   logic          printed_q, printed_d;

   logic [3:0] opcode;
   logic       is_print;
   logic       sync_stall;
   logic       print_stall;
   logic       advance;

   assign opcode      = ins_q[15:12];
   assign is_print    = (opcode == OP_PRINT);
   assign current_ins = ins_q;
   assign ptr_wb      = ptr_q;

   always_comb begin
      num_syncs = '0;
      for (int i = 0; i < NCORES; i++) begin
         if (all_ins[16*i+12 +: 4] == OP_SYNC && all_ins[16*i +: 8] == ins_q[7:0])
            num_syncs = num_syncs + SW'(1);
      end
   end

   // A target of 0 can never match because this core always counts itself.
   assign sync_stall = (opcode == OP_SYNC) && (32'(num_syncs) != 32'(ins_q[11:8]));
   assign stall      = sync_stall || print_stall;
   assign advance    = !stall && !core_stall;

   always_comb begin
      ins_d = ins_q;
      val_d = val_q;
      ptr_d = ptr_q;
      if (advance) begin
         ins_d = ins_in;
         val_d = val_in;
         ptr_d = ptr_select;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ins_q <= '0;
         val_q <= '0;
         ptr_q <= PW'(PTR_INIT);
      end else begin
         ins_q <= ins_d;
         val_q <= val_d;
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      val_out    = '0;
      wb_en      = 1'b0;
      branch_val = '0;
      branch_en  = 1'b0;
      ptr_select = ptr_q;
      case (opcode)
         OP_PLUS:  begin val_out = val_q + DW'(1); wb_en = 1'b1; end
         OP_MINUS: begin val_out = val_q - DW'(1); wb_en = 1'b1; end
         OP_ADDK:  begin
            val_out = val_q + {{(DW-8){ins_q[7]}}, ins_q[7:0]};
            wb_en   = 1'b1;
         end
         OP_INC:   ptr_select = ptr_q + PW'(1);
         OP_DEC:   ptr_select = ptr_q - PW'(1);
         OP_MOVK:  ptr_select = ptr_q + {{(PW-12){ins_q[11]}}, ins_q[11:0]};
         OP_BR:    begin branch_val = {4'h0, ins_q[11:0]}; branch_en = 1'b1; end
         OP_BRZ:   begin
            if (val_q == '0) begin
               branch_val = {4'h0, ins_q[11:0]};
               branch_en  = 1'b1;
            end
         end
         default:  ;
      endcase
      // Side effects only count in a cycle that actually retires the instruction.
      if (!advance) begin
         val_out    = '0;
         wb_en      = 1'b0;
         branch_val = '0;
         branch_en  = 1'b0;
      end
      if (fork_valid)
         ptr_select = fork_ptr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         printed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         printed_q <= printed_d;
      end
   end

   // printed_q remembers a transfer accepted while core_stall held the PRINT in place.
   always_comb begin
      state_d   = state_q;
      printed_d = printed_q;
      case (state_q)
         IDLE: if (is_print && !printed_q && !print_ready) state_d = HOLD;
         HOLD: if (print_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (advance)
         printed_d = 1'b0;
      else if (print_valid && print_ready)
         printed_d = 1'b1;
   end

   always_comb begin
      print_valid = 1'b0;
      print_data  = '0;
      print_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_print && !printed_q) begin
               print_valid = 1'b1;
               print_data  = val_q;
               print_stall = !print_ready;
            end
         end
         HOLD: begin
            print_valid = 1'b1;
            print_data  = val_q;
            print_stall = !print_ready;
         end
         default: ;
      endcase
   end

endmodule
